// File: rtl/uart_fifo_if.sv
// uart_fifo_if: byte-buffering front end for the uart core.
//
// A TX FIFO queues bytes from the system side. A two-state launcher hands them
// to the UART one at a time. An RX FIFO captures received bytes and sets a
// sticky overrun flag when a byte has to be dropped.
//
// Ports:
//   clk, rst                 system clock; synchronous active-high reset
//   wr_en, wr_data           push a byte into the TX FIFO (dropped while tx_full)
//   rd_en, rd_data           pop / show-ahead head of the RX FIFO
//   clr_overrun              clears rx_overrun (a simultaneous drop wins)
//   tx_full, tx_empty        TX FIFO status
//   tx_count                 TX FIFO occupancy, 0..2**ADDR_W
//   rx_full, rx_empty        RX FIFO status
//   rx_count                 RX FIFO occupancy, 0..2**ADDR_W
//   rx_overrun               sticky: a received byte was dropped
//   tx_busy                  a byte is in flight in the UART transmitter
//   tx_start, tx_din         one-cycle launch pulse and held byte to the UART
//   tx_done_tick             UART finished the current byte
//   rx_done_tick, rx_dout    UART received a byte, valid this cycle
module uart_fifo_if #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              rd_en,
  output logic [DBIT-1:0]   rd_data,
  input  logic              clr_overrun,
  output logic              tx_full,
  output logic              tx_empty,
  output logic [ADDR_W:0]   tx_count,
  output logic              rx_full,
  output logic              rx_empty,
  output logic [ADDR_W:0]   rx_count,
  output logic              rx_overrun,
  output logic              tx_busy,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_dout
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(Depth);

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DBIT-1:0]   tx_mem [Depth];
  logic [ADDR_W-1:0] tx_wptr_q, tx_rptr_q;
  logic [ADDR_W:0]   tx_count_q;
  logic              tx_push, tx_pop;

  typedef enum logic {StIdle, StBusy} tx_state_e;
  tx_state_e         tx_state_q;
  logic              tx_start_q, tx_busy_q;
  logic [DBIT-1:0]   tx_din_q;

  assign tx_full  = (tx_count_q == FullCnt);
  assign tx_empty = (tx_count_q == '0);
  assign tx_count = tx_count_q;

  // Fullness is judged before the edge, so a write while full is lost even if
  // the launcher pops in the same cycle.
  assign tx_push = wr_en & ~tx_full;
  assign tx_pop  = (tx_state_q == StIdle) & ~tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_count_q <= tx_count_q + (ADDR_W + 1)'(tx_push) - (ADDR_W + 1)'(tx_pop);
    end
  end

  // Launcher: IDLE pops the head into tx_din and pulses tx_start; BUSY waits
  // for tx_done_tick. Returning to IDLE on the tick means the next launch is
  // one edge later, giving the one-cycle gap between bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_start_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_din_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (tx_state_q)
        StIdle: begin
          if (!tx_empty) begin
            tx_din_q   <= tx_mem[tx_rptr_q];
            tx_start_q <= 1'b1;
            tx_busy_q  <= 1'b1;
            tx_state_q <= StBusy;
          end
        end
        StBusy: begin
          if (tx_done_tick) begin
            tx_busy_q  <= 1'b0;
            tx_state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_busy  = tx_busy_q;
  assign tx_din   = tx_din_q;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [DBIT-1:0]   rx_mem [Depth];
  logic [ADDR_W-1:0] rx_wptr_q, rx_rptr_q;
  logic [ADDR_W:0]   rx_count_q;
  logic              rx_overrun_q;
  logic              rx_push, rx_pop, rx_drop;

  assign rx_full    = (rx_count_q == FullCnt);
  assign rx_empty   = (rx_count_q == '0);
  assign rx_count   = rx_count_q;
  assign rx_overrun = rx_overrun_q;
  assign rd_data    = rx_mem[rx_rptr_q];

  assign rx_pop  = rd_en & ~rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push = rx_done_tick & (~rx_full | rd_en);
  assign rx_drop = rx_done_tick & ~rx_push;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_count_q   <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_count_q <= rx_count_q + (ADDR_W + 1)'(rx_push) - (ADDR_W + 1)'(rx_pop);
      // Set has priority over clear.
      if (rx_drop)          rx_overrun_q <= 1'b1;
      else if (clr_overrun) rx_overrun_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_if.sv
module tb_uart_fifo_if;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clr_overrun, tx_done_tick, rx_done_tick;
  logic [7:0] wr_data, rx_dout, rd_data, tx_din;
  logic       tx_full, tx_empty, rx_full, rx_empty, rx_overrun, tx_busy, tx_start;
  logic [4:0] tx_count, rx_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_fifo_if #(.DBIT(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .clr_overrun  (clr_overrun),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_count     (tx_count),
    .rx_full      (rx_full),
    .rx_empty     (rx_empty),
    .rx_count     (rx_count),
    .rx_overrun   (rx_overrun),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout)
  );

  // Reference model: queues plus a "byte in flight" flag.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_busy, m_start, m_ovr;
  logic [7:0] m_din;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_tx_start", 32'(tx_start), 32'(m_start));
    check("m_tx_din", 32'(tx_din), 32'(m_din));
    check("m_tx_busy", 32'(tx_busy), 32'(m_busy));
    check("m_tx_count", 32'(tx_count), tx_q.size());
    check("m_tx_full", 32'(tx_full), 32'(tx_q.size() == 16));
    check("m_tx_empty", 32'(tx_empty), 32'(tx_q.size() == 0));
    check("m_rx_count", 32'(rx_count), rx_q.size());
    check("m_rx_full", 32'(rx_full), 32'(rx_q.size() == 16));
    check("m_rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
    check("m_rx_overrun", 32'(rx_overrun), 32'(m_ovr));
    if (rx_q.size() != 0) check("m_rd_data", 32'(rd_data), 32'(rx_q[0]));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic i_rst, input logic i_wr, input logic [7:0] i_wd,
                      input logic i_rd, input logic i_rxd, input logic [7:0] i_rxv,
                      input logic i_clr, input logic i_done);
    int  rxn;
    bit  launch, txfull, popok, pushok;
    rst = i_rst; wr_en = i_wr; wr_data = i_wd; rd_en = i_rd;
    rx_done_tick = i_rxd; rx_dout = i_rxv; clr_overrun = i_clr; tx_done_tick = i_done;
    @(posedge clk);
    if (i_rst) begin
      tx_q.delete(); rx_q.delete();
      m_busy = 0; m_start = 0; m_din = 8'h00; m_ovr = 0;
    end else begin
      launch  = !m_busy && tx_q.size() != 0;
      txfull  = tx_q.size() == 16;
      m_start = launch;
      if (launch) begin
        m_din  = tx_q.pop_front();
        m_busy = 1;
      end else if (m_busy && i_done) begin
        m_busy = 0;
      end
      if (i_wr && !txfull) tx_q.push_back(i_wd);
      rxn    = rx_q.size();
      popok  = i_rd && rxn > 0;
      pushok = i_rxd && (rxn < 16 || i_rd);
      if (popok) void'(rx_q.pop_front());
      if (pushok) rx_q.push_back(i_rxv);
      if (i_rxd && !pushok) m_ovr = 1;
      else if (i_clr)       m_ovr = 0;
    end
    #1;
    compare_model();
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  typedef struct {
    logic       rst, wr;
    logic [7:0] wd;
    logic       rd, rxd;
    logic [7:0] rxv;
    logic       clr, done;
    logic       e_start;
    logic [7:0] e_din;
    logic       e_busy;
    logic [4:0] e_txc, e_rxc;
    logic       e_ovr, chk_rd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vt[12];

  initial begin
    //          rst wr wd     rd rxd rxv    clr dn  st din    bsy txc   rxc   ovr ck rd
    vt[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[1]  = '{0, 1, 8'hA5, 0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 5'd1, 5'd0, 0, 0, 8'h00};
    vt[2]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 8'hA5, 1, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[3]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 8'hA5, 1, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[4]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'hA5, 0, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[5]  = '{0, 0, 8'h00, 0, 1, 8'h3C, 0, 0,  0, 8'hA5, 0, 5'd0, 5'd1, 0, 1, 8'h3C};
    vt[6]  = '{0, 0, 8'h00, 1, 1, 8'h5A, 0, 0,  0, 8'hA5, 0, 5'd0, 5'd1, 0, 1, 8'h5A};
    vt[7]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[8]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0,  0, 8'hA5, 0, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[9]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1, 1,  0, 8'hA5, 0, 5'd0, 5'd0, 0, 0, 8'h00};
    vt[10] = '{0, 1, 8'h11, 0, 1, 8'h22, 0, 1,  0, 8'hA5, 0, 5'd1, 5'd1, 0, 1, 8'h22};
    vt[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 8'h11, 1, 5'd0, 5'd1, 0, 1, 8'h22};

    {rst, wr_en, wr_data, rd_en, rx_done_tick, rx_dout, clr_overrun, tx_done_tick} = '0;

    // Table: reset values, single byte launch, RX show-ahead, pops, ignores.
    for (int i = 0; i < 12; i++) begin
      step(vt[i].rst, vt[i].wr, vt[i].wd, vt[i].rd, vt[i].rxd, vt[i].rxv,
           vt[i].clr, vt[i].done);
      check($sformatf("v%0d_tx_start", i), 32'(tx_start), 32'(vt[i].e_start));
      check($sformatf("v%0d_tx_din", i), 32'(tx_din), 32'(vt[i].e_din));
      check($sformatf("v%0d_tx_busy", i), 32'(tx_busy), 32'(vt[i].e_busy));
      check($sformatf("v%0d_tx_count", i), 32'(tx_count), 32'(vt[i].e_txc));
      check($sformatf("v%0d_rx_count", i), 32'(rx_count), 32'(vt[i].e_rxc));
      check($sformatf("v%0d_rx_overrun", i), 32'(rx_overrun), 32'(vt[i].e_ovr));
      if (vt[i].chk_rd) check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vt[i].e_rd));
    end

    // TX fill and overflow with the UART stalled.
    do_reset();
    for (int i = 0; i < 18; i++) step(0, 1, 8'(i), 0, 0, 8'h00, 0, 0);
    check("fill_tx_count", 32'(tx_count), 32'd16);
    check("fill_tx_full", 32'(tx_full), 32'd1);
    check("fill_tx_din", 32'(tx_din), 32'h00);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
      check("drain_busy_low", 32'(tx_busy), 32'd0);
      idle();
      check("drain_start", 32'(tx_start), 32'd1);
      check("drain_din", 32'(tx_din), 32'(i));
    end
    check("drain_tx_count", 32'(tx_count), 32'd0);
    check("drain_tx_empty", 32'(tx_empty), 32'd1);
    step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    idle();
    check("dropped_no_start", 32'(tx_start), 32'd0);
    check("dropped_idle", 32'(tx_busy), 32'd0);

    // RX overrun, in-order reads, clear.
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, 8'h00, 0, 1, 8'(8'h30 + i), 0, 0);
    check("ovr_rx_count", 32'(rx_count), 32'd16);
    check("ovr_flag", 32'(rx_overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("ovr_read", 32'(rd_data), 32'(8'h30 + i));
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    end
    check("ovr_empty", 32'(rx_empty), 32'd1);
    check("ovr_still_set", 32'(rx_overrun), 32'd1);
    step(0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    check("ovr_cleared", 32'(rx_overrun), 32'd0);

    // RX full with simultaneous pop and push.
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1, 8'(8'h60 + i), 0, 0);
    step(0, 0, 8'h00, 1, 1, 8'h77, 0, 0);
    check("simul_ovr", 32'(rx_overrun), 32'd0);
    check("simul_count", 32'(rx_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("simul_read", 32'(rd_data), (i < 15) ? 32'(8'h61 + i) : 32'h77);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    end

    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1, 8'(8'h80 + i), 0, 0);
    check("setclr_pre", 32'(rx_overrun), 32'd0);
    step(0, 0, 8'h00, 0, 1, 8'h99, 1, 0);
    check("setclr_set_wins", 32'(rx_overrun), 32'd1);

    // Reset mid-transmission with queued TX and held RX bytes.
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'hC0 + i), 0, i < 3, 8'(8'hD0 + i), 0, 0);
    check("mid_tx_count", 32'(tx_count), 32'd5);
    check("mid_busy", 32'(tx_busy), 32'd1);
    check("mid_rx_count", 32'(rx_count), 32'd3);
    do_reset();
    check("rst_outputs", {tx_start, tx_din, tx_busy, tx_full, tx_empty, tx_count,
                          rx_full, rx_empty, rx_count, rx_overrun},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      idle();
      check("rst_no_start", 32'(tx_start), 32'd0);
    end
    step(0, 1, 8'hE7, 0, 0, 8'h00, 0, 0);
    idle();
    check("rst_new_start", 32'(tx_start), 32'd1);
    check("rst_new_din", 32'(tx_din), 32'hE7);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 99) < 50), 8'($urandom),
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 40), 8'($urandom),
           ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_if.md
# uart_fifo_if

Byte-buffering front end for the `uart` core. It sits between the system side (processor or streaming logic) and the UART's `din`/`tx_start`/`tx_done_tick` and `dout`/`rx_done_tick` handshakes. It queues outgoing bytes in a TX FIFO and launches them one at a time. It also captures received bytes into an RX FIFO with sticky overrun detection, so neither side has to track per-byte UART timing.

## Interface
- `DBIT`, 8, data bits per character; matches the UART's `DBIT`.
- `ADDR_W`, 4, FIFO address width; each FIFO depth is 2**ADDR_W (16).

Ports, clock and reset first:
- `clk` in 1: the single system clock, shared with `uart`.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: push `wr_data` into the TX FIFO.
- `wr_data` in DBIT: byte to transmit.
- `rd_en` in 1: pop the RX FIFO head.
- `rd_data` out DBIT: RX FIFO head, show-ahead; valid while `rx_empty`=0.
- `clr_overrun` in 1: clears `rx_overrun`.
- `tx_full`, `tx_empty` out 1: TX FIFO status.
- `tx_count` out ADDR_W+1: TX FIFO occupancy, 0..2**ADDR_W.
- `rx_full`, `rx_empty` out 1: RX FIFO status.
- `rx_count` out ADDR_W+1: RX FIFO occupancy.
- `rx_overrun` out 1: sticky flag; a received byte was dropped.
- `tx_busy` out 1: a byte is in flight in the UART transmitter.
- `tx_start` out 1: one-cycle launch pulse to `uart`.
- `tx_din` out DBIT: byte to `uart.din`; held stable from launch until the next launch.
- `tx_done_tick` in 1: from `uart`; the current byte has completed, including stop bits.
- `rx_done_tick` in 1: from `uart`; `rx_dout` is valid this cycle.
- `rx_dout` in DBIT: received byte from `uart.dout`.

## Operation
- **FIFOs.** Two independent circular buffers.
  - Read and write pointers are ADDR_W bits wide and wrap modulo 2**ADDR_W.
  - Occupancy counters are ADDR_W+1 bits wide.
  - full ⇔ count = 2**ADDR_W; empty ⇔ count = 0.
- **TX push.** `wr_en` is accepted only if `tx_full`=0 before the edge.
  - A write while full is silently dropped, even if a TX pop happens in the same cycle.
  - `tx_full` is the upstream ready signal.
- **TX FSM, states IDLE and BUSY.**
  - IDLE with `tx_empty`=0: register `tx_din` ← head, pulse `tx_start`=1 for exactly one cycle, advance the read pointer, go to BUSY.
  - BUSY: `tx_busy`=1. Wait for `tx_done_tick`, then go to IDLE. No launch happens in the same cycle as `tx_done_tick`.
  - IDLE with `tx_empty`=1: stay in IDLE, `tx_start`=0.
  - `tx_done_tick` while in IDLE is ignored.
- **RX push.** On `rx_done_tick`, `rx_dout` is written if `rx_full`=0, or if `rx_full`=1 and `rd_en` pops in the same cycle. In that simultaneous case the count stays at 2**ADDR_W.
  - Otherwise the byte is dropped and `rx_overrun` is set.
- **RX pop.** `rd_en` with `rx_empty`=0 advances the read pointer.
  - `rd_en` while empty is ignored; no pointer movement and no underflow.
- **Simultaneous push and pop on a non-full, non-empty FIFO:** both take effect and the count is unchanged.
- **`rx_overrun`.** Cleared by `clr_overrun`. If a drop and `clr_overrun` occur in the same cycle, set wins.
- **Reset, including mid-transmission.** Both FIFOs are emptied and the FSM returns to IDLE. Queued and in-flight bytes are discarded. `uart` shares `rst`.

## Timing
- **Reset values:** `tx_start`=0, `tx_din`=0, `tx_busy`=0, `tx_full`=0, `tx_empty`=1, `tx_count`=0, `rx_full`=0, `rx_empty`=1, `rx_count`=0, `rx_overrun`=0. `rd_data` is don't-care while empty.
- **Status outputs** are registered and reflect the state after the last edge.
- **Write to an empty, idle TX path:** `wr_en` is sampled at edge k. `tx_empty` goes to 0 after k. `tx_start`=1 during the cycle following edge k+1 and returns to 0 after edge k+2. `tx_busy`=1 from edge k+1.
- **Back-to-back bytes:** `tx_done_tick` is sampled at edge m. The next `tx_start` is high in the cycle after edge m+1, a one-cycle gap.
- **RX latency:** `rx_done_tick` at edge k gives `rd_data` = that byte and `rx_empty`=0 after edge k, for a byte written into an empty FIFO.
- **RX pop:** `rd_data` updates to the next entry after the popping edge.

## Test plan
1. **Single byte.**
   - Stimulus: reset, then one `wr_en` with 0xA5.
   - Required: `tx_start` is a one-cycle pulse one cycle after the write, with `tx_din`=0xA5. `tx_busy` holds until `tx_done_tick`. `tx_empty`=1 afterwards.
2. **TX fill and overflow.**
   - Stimulus: with the UART stalled (no `tx_done_tick`), write 18 bytes 0x00..0x11.
   - Required: 0x00 is launched and 0x01..0x10 are queued. `tx_count`=16, `tx_full`=1, and 0x11 is dropped.
   - Then: feed 16 `tx_done_tick`s. Required: `tx_din` sequence is 0x01..0x10 and `tx_count` wraps cleanly to 0.
3. **RX overrun and clear.**
   - Stimulus: 17 `rx_done_tick`s carrying 0x30..0x40 with no reads.
   - Required: `rx_count`=16, `rx_overrun`=1, and 0x40 is dropped. Reads return 0x30..0x3F in order.
   - Then: assert `clr_overrun`. Required: the flag clears.
4. **RX full with simultaneous read and push.**
   - Stimulus: RX FIFO full, then `rd_en` and `rx_done_tick` (0x77) in the same cycle.
   - Required: `rx_overrun` stays 0, `rx_count` stays 16, and 0x77 is read last.
5. **Overrun and clear in the same cycle.**
   - Stimulus: `clr_overrun` coinciding with a dropped byte.
   - Required: `rx_overrun`=1.
6. **Reset mid-operation.**
   - Stimulus: assert `rst` while in BUSY with 5 bytes queued and 3 RX bytes held.
   - Required: all outputs return to their reset values the next cycle. No `tx_start` occurs until a new `wr_en`.
